// File: rtl/hpi_responder.sv
// Device-side responder for the OTG Host Port Interface: address register,
// auto-incrementing data window into a local word RAM, two one-deep mailboxes.
module hpi_responder #(
  parameter int MEM_AW = 10
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [1:0]  hpi_address,
  input  logic        hpi_cs_n,
  input  logic        hpi_r_n,
  input  logic        hpi_w_n,
  input  logic        hpi_reset_n,
  input  logic [15:0] hpi_data_in,
  output logic [15:0] hpi_data_out,
  output logic        hpi_data_oe,
  output logic        hpi_irq,
  output logic [15:0] mbx_h2l_data,
  output logic        mbx_h2l_full,
  input  logic        mbx_h2l_rd,
  input  logic [15:0] mbx_l2h_data,
  input  logic        mbx_l2h_wr
);

  localparam logic [1:0] A_DATA = 2'd0;
  localparam logic [1:0] A_MBX  = 2'd1;
  localparam logic [1:0] A_ADDR = 2'd2;
  localparam logic [1:0] A_STAT = 2'd3;

  logic        rd_cond, wr_cond, rd_commit, wr_commit;
  logic        rd_prev_q, rd_prev_d, wr_prev_q, wr_prev_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] h2l_data_q, h2l_data_d;
  logic        h2l_full_q, h2l_full_d;
  logic [15:0] l2h_data_q, l2h_data_d;
  logic        l2h_full_q, l2h_full_d;
  logic        ovf_q, ovf_d;
  logic        irq_q, irq_d;
  logic        oe_q, oe_d;
  logic [15:0] dout_q, dout_d;
  logic        rd_pend_q, rd_pend_d;
  logic        rd_ram_sel_q, rd_ram_sel_d;
  logic [15:0] rd_hold_q, rd_hold_d;
  logic        ram_we, ram_re;
  logic [15:0] ram_rd_q;
  logic [15:0] mem [0:(2**MEM_AW)-1];
  logic [MEM_AW-1:0] ram_idx;

  assign rd_cond   = !hpi_cs_n && !hpi_r_n && hpi_w_n;
  assign wr_cond   = !hpi_cs_n && !hpi_w_n && hpi_r_n;
  assign rd_commit = rd_cond && !rd_prev_q && hpi_reset_n;
  assign wr_commit = wr_cond && !wr_prev_q && hpi_reset_n;
  assign ram_idx   = addr_q[MEM_AW:1];

  assign hpi_data_out = dout_q;
  assign hpi_data_oe  = oe_q;
  assign hpi_irq      = irq_q;
  assign mbx_h2l_data = h2l_data_q;
  assign mbx_h2l_full = h2l_full_q;

  always_comb begin
    // Strobe history is tracked even in soft reset so a held strobe cannot commit on release.
    rd_prev_d    = rd_cond;
    wr_prev_d    = wr_cond;
    addr_d       = addr_q;
    h2l_data_d   = h2l_data_q;
    h2l_full_d   = h2l_full_q;
    l2h_data_d   = l2h_data_q;
    l2h_full_d   = l2h_full_q;
    ovf_d        = ovf_q;
    dout_d       = dout_q;
    rd_pend_d    = rd_commit;
    rd_ram_sel_d = rd_ram_sel_q;
    rd_hold_d    = rd_hold_q;
    ram_we       = 1'b0;
    ram_re       = 1'b0;
    oe_d         = 1'b0;
    irq_d        = 1'b0;
    if (!hpi_reset_n) begin
      addr_d     = 16'h0000;
      h2l_data_d = 16'h0000;
      h2l_full_d = 1'b0;
      l2h_data_d = 16'h0000;
      l2h_full_d = 1'b0;
      ovf_d      = 1'b0;
      dout_d     = 16'h0000;
    end else begin
      if (mbx_h2l_rd) begin
        h2l_full_d = 1'b0;
      end else begin
        h2l_full_d = h2l_full_q;
      end
      // Reads latch their pre-side-effect value now; it reaches the pins next cycle.
      if (rd_commit) begin
        rd_ram_sel_d = (hpi_address == A_DATA);
        case (hpi_address)
          A_DATA: begin
            ram_re    = 1'b1;
            addr_d    = addr_q + 16'd2;
            rd_hold_d = 16'h0000;
          end
          A_MBX: begin
            rd_hold_d  = l2h_data_q;
            l2h_full_d = 1'b0;
          end
          A_ADDR:  rd_hold_d = addr_q;
          A_STAT: begin
            rd_hold_d = {13'd0, ovf_q, l2h_full_q, h2l_full_q};
            ovf_d     = 1'b0;
          end
          default: rd_hold_d = 16'h0000;
        endcase
      end else if (wr_commit) begin
        case (hpi_address)
          A_DATA: begin
            ram_we = 1'b1;
            addr_d = addr_q + 16'd2;
          end
          A_MBX: begin
            h2l_data_d = hpi_data_in;
            h2l_full_d = 1'b1;
            ovf_d      = ovf_q | h2l_full_q;
          end
          A_ADDR:  addr_d = hpi_data_in;
          A_STAT:  addr_d = addr_q;
          default: addr_d = addr_q;
        endcase
      end else begin
        rd_hold_d = rd_hold_q;
      end
      // Local load comes after the host read so a same-cycle load keeps the mailbox full.
      if (mbx_l2h_wr) begin
        l2h_data_d = mbx_l2h_data;
        l2h_full_d = 1'b1;
      end else begin
        l2h_data_d = l2h_data_d;
      end
      if (rd_pend_q) begin
        dout_d = rd_ram_sel_q ? ram_rd_q : rd_hold_q;
      end else begin
        dout_d = dout_q;
      end
      oe_d  = rd_cond && (rd_pend_q || oe_q);
      irq_d = l2h_full_d;
    end
  end

  // Register state; strobe history resets high so an access spanning reset is not replayed.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      rd_prev_q    <= 1'b1;
      wr_prev_q    <= 1'b1;
      addr_q       <= 16'h0000;
      h2l_data_q   <= 16'h0000;
      h2l_full_q   <= 1'b0;
      l2h_data_q   <= 16'h0000;
      l2h_full_q   <= 1'b0;
      ovf_q        <= 1'b0;
      irq_q        <= 1'b0;
      oe_q         <= 1'b0;
      dout_q       <= 16'h0000;
      rd_pend_q    <= 1'b0;
      rd_ram_sel_q <= 1'b0;
      rd_hold_q    <= 16'h0000;
    end else begin
      rd_prev_q    <= rd_prev_d;
      wr_prev_q    <= wr_prev_d;
      addr_q       <= addr_d;
      h2l_data_q   <= h2l_data_d;
      h2l_full_q   <= h2l_full_d;
      l2h_data_q   <= l2h_data_d;
      l2h_full_q   <= l2h_full_d;
      ovf_q        <= ovf_d;
      irq_q        <= irq_d;
      oe_q         <= oe_d;
      dout_q       <= dout_d;
      rd_pend_q    <= rd_pend_d;
      rd_ram_sel_q <= rd_ram_sel_d;
      rd_hold_q    <= rd_hold_d;
    end
  end

  // Word RAM with synchronous read; contents survive both resets.
  always_ff @(posedge Clk) begin
    if (ram_we) begin
      mem[ram_idx] <= hpi_data_in;
    end
    if (ram_re) begin
      ram_rd_q <= mem[ram_idx];
    end
  end

endmodule

// File: doc/hpi_responder.md
# hpi_responder

Device-side model of the OTG Host Port Interface (HPI): the responder that answers the 2-bit-address, chip-select/read/write, 16-bit-data accesses the Nios II issues through its OTG HPI PIO exports. It holds an address register, an auto-incrementing data window into a local word RAM, and two one-deep mailboxes with a status register. It lets the keycode/USB software path run against on-chip hardware in place of the external EZ-OTG part. It also serves as the device model in system simulation.

## Interface
- MEM_AW, 10: word-address width of the internal RAM (2^MEM_AW x 16 bits).
- Clk  in  1  system clock; every input is sampled on its rising edge.
- Reset  in  1  asynchronous, active-high reset.
- hpi_address  in  2  register select: 0 DATA, 1 MAILBOX, 2 ADDRESS, 3 STATUS.
- hpi_cs_n  in  1  chip select, active low.
- hpi_r_n  in  1  read strobe, active low.
- hpi_w_n  in  1  write strobe, active low.
- hpi_reset_n  in  1  HPI soft reset, active low, synchronous.
- hpi_data_in  in  16  host write data.
- hpi_data_out  out  16  read data returned to the host.
- hpi_data_oe  out  1  high while the responder drives read data.
- hpi_irq  out  1  high while the local-to-host mailbox is full.
- mbx_h2l_data  out  16  last host-written mailbox word.
- mbx_h2l_full  out  1  host-to-local mailbox holds unread data.
- mbx_h2l_rd  in  1  one-cycle pulse: local side consumed the mailbox.
- mbx_l2h_data  in  16  local-to-host mailbox word.
- mbx_l2h_wr  in  1  one-cycle pulse: load mbx_l2h_data into the mailbox.

## Operation
- A read access is cs_n=0 and r_n=0 and w_n=1.
- A write access is cs_n=0 and w_n=0 and r_n=1.
- An access is committed once, on the first clock edge at which its condition holds after a cycle in which it did not hold. Holding the strobes low gives no repeat.
- cs_n=0 with both r_n and w_n low is illegal: ignored, no side effects.
- ADDRESS write: addr_reg <= hpi_data_in (a byte address). ADDRESS read returns addr_reg.
- DATA access targets RAM word addr_reg[MEM_AW:1]; addr_reg[0] is ignored.
  - Write stores hpi_data_in. Read returns the stored word.
  - Both then do addr_reg <= addr_reg + 2, modulo 2^16 (0xFFFE wraps to 0x0000).
  - Addresses above the RAM size alias.
- MAILBOX write: mbx_h2l_data <= hpi_data_in, mbx_h2l_full <= 1. If the mailbox was already full, the sticky overflow flag is set.
- MAILBOX read returns the l2h mailbox word and clears l2h_full.
- STATUS read returns {13'b0, overflow, l2h_full, h2l_full}, then clears overflow. STATUS writes are ignored.
- mbx_h2l_rd clears h2l_full. A host MAILBOX write in the same cycle wins: full stays 1, holds the new data, and overflow is set.
- mbx_l2h_wr loads the l2h word and sets l2h_full. A host MAILBOX read in the same cycle returns the old word and l2h_full stays 1. An l2h write while full overwrites silently.
- hpi_irq = l2h_full (registered).
- hpi_reset_n=0 forces the same register state as Reset. RAM contents are preserved. Accesses are ignored while it is low.

## Timing
- Reset or hpi_reset_n=0 values:
  - addr_reg 0.
  - hpi_data_out 0, hpi_data_oe 0.
  - hpi_irq 0.
  - mbx_h2l_data 0, mbx_h2l_full 0.
  - l2h word 0, l2h_full 0.
  - overflow 0.
- Write latency: register or RAM updated at the commit edge; the effect is visible to an access committed at the next edge.
- Read latency: hpi_data_out valid one cycle after the commit edge. It holds until the next committed read or reset.
- hpi_data_oe rises one cycle after the commit edge. It falls on the edge after the read condition drops.
- Side effects (auto-increment, flag clears) take effect at the commit edge. The returned value is the pre-side-effect value.
- RAM is a synchronous-read block; the one-cycle read latency covers it.
- Minimum host cycle: strobes deasserted for one Clk period between accesses.
- Reset asserted mid-access: outputs go to reset values immediately. The access in progress is not committed after release unless its strobe edge recurs.

## Test plan
- Write ADDRESS=0x0010, then DATA writes 0x1111, 0x2222. Write ADDRESS=0x0010, then two DATA reads -> returns 0x1111, 0x2222; ADDRESS reads 0x0014.
- ADDRESS=0xFFFE, DATA write 0xBEEF -> ADDRESS reads 0x0000. Word 0xFFFE>>1 aliased into RAM reads 0xBEEF.
- Host MAILBOX write 0x00A5 -> mbx_h2l_full=1, STATUS=0x0001. Second write 0x005A without mbx_h2l_rd -> STATUS=0x0005 and data 0x005A. A further STATUS read returns 0x0001.
- mbx_l2h_wr with 0x1234 -> hpi_irq=1. MAILBOX read returns 0x1234 and hpi_irq=0 next cycle. The same-cycle mbx_l2h_wr 0x5678 plus host read returns 0x1234 and irq stays 1.
- Hold cs_n/r_n low 10 cycles on DATA -> exactly one auto-increment. r_n and w_n both low -> no state change.
- Pulse hpi_reset_n mid-sequence -> addr_reg, flags and outputs are 0, and RAM data written earlier is still readable.
